// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store unit that computes the address, checks legality and
// alignment, and runs one memory transaction per operation with an ack timeout.
// Latency: accept at edge N, request from N; zero-wait ack gives done/wb at N+1,
// ready again at N+2.
// Backpressure: o_ready is high only in IDLE. Operations are held off while a
// request or release is in flight.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/i_is_load/
//        i_is_store/i_funct3/i_base/i_offset/i_store_data upstream op; o_ready;
//        o_mem_* / i_mem_ack / i_mem_data memory side; o_wb_valid/o_wb_data/
//        o_done/o_misaligned/o_illegal/o_bus_error/o_fault_addr results.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_is_load,
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_offset,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_ready,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_data,
    output logic [2:0]      o_mem_funct3,
    output logic            o_mem_read_write,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_data,
    output logic            o_wb_valid,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_done,
    output logic            o_misaligned,
    output logic            o_illegal,
    output logic            o_bus_error,
    output logic [XLEN-1:0] o_fault_addr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            rw_q, rw_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [XLEN-1:0] fault_q, fault_d;
    logic            wb_valid_q, wb_valid_d;
    logic            done_q, done_d;
    logic            mis_q, mis_d;
    logic            ill_q, ill_d;
    logic            berr_q, berr_d;

    logic [XLEN-1:0] eff_addr;
    logic            fire;
    logic            op_illegal;
    logic            op_misaligned;

    // Carry-out of the address add is deliberately dropped (wraps mod 2^XLEN).
    assign eff_addr = i_base + i_offset;
    assign fire     = i_valid && (state_q == IDLE) && (i_is_load || i_is_store);

    // Loads allow LB/LH/LW/LBU/LHU; stores allow SB/SH/SW only.
    assign op_illegal = (i_is_load && i_is_store)
                     || (i_is_load && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)
                                       || (i_funct3 == 3'b111)))
                     || (i_is_store && (i_funct3 > 3'b010));

    assign op_misaligned = ((i_funct3[1:0] == 2'b01) && eff_addr[0])
                        || ((i_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        funct3_d   = funct3_q;
        rw_d       = rw_q;
        wb_data_d  = wb_data_q;
        fault_d    = fault_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        ill_d      = 1'b0;
        berr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (op_illegal) begin
                        ill_d   = 1'b1;
                        fault_d = eff_addr;
                    end else if (op_misaligned) begin
                        mis_d   = 1'b1;
                        fault_d = eff_addr;
                    end else begin
                        state_d  = REQ;
                        cnt_d    = '0;
                        addr_d   = eff_addr;
                        data_d   = i_store_data;
                        funct3_d = i_funct3;
                        rw_d     = i_is_store;
                    end
                end
            end
            REQ: begin
                // Ack wins over timeout when both land on the same edge.
                if (i_mem_ack) begin
                    done_d  = 1'b1;
                    state_d = RELEASE;
                    if (!rw_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = i_mem_data;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    berr_d  = 1'b1;
                    fault_d = addr_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                // Wait for the memory to drop ack so one ack is never seen twice.
                if (!i_mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            funct3_q   <= '0;
            rw_q       <= 1'b0;
            wb_data_q  <= '0;
            fault_q    <= '0;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            funct3_q   <= funct3_d;
            rw_q       <= rw_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
            wb_valid_q <= wb_valid_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
            berr_q     <= berr_d;
        end
    end

    // Request is a pure decode of the registered state, so reset drops it at once.
    assign o_ready          = (state_q == IDLE);
    assign o_mem_req        = (state_q == REQ);
    assign o_mem_addr       = addr_q;
    assign o_mem_data       = data_q;
    assign o_mem_funct3     = funct3_q;
    assign o_mem_read_write = rw_q;
    assign o_wb_valid       = wb_valid_q;
    assign o_wb_data        = wb_data_q;
    assign o_done           = done_q;
    assign o_misaligned     = mis_q;
    assign o_illegal        = ill_q;
    assign o_bus_error      = berr_q;
    assign o_fault_addr     = fault_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: data/address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for memory acknowledge.
REQ-003 The block SHALL have port i_clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_valid, input, 1: upstream memory operation offered.
REQ-006 The block SHALL have port i_is_load, input, 1: the offered operation is a load.
REQ-007 The block SHALL have port i_is_store, input, 1: the offered operation is a store.
REQ-008 The block SHALL have port i_funct3, input, 3: RV32I load/store width code.
REQ-009 The block SHALL have ports i_base and i_offset, input, XLEN each: base register value and sign-extended immediate.
REQ-010 The block SHALL have port i_store_data, input, XLEN: rs2 value.
REQ-011 The block SHALL have port o_ready, output, 1: the block accepts an operation this cycle.
REQ-012 The block SHALL have memory-side outputs o_mem_req (1), o_mem_addr (XLEN), o_mem_data (XLEN), o_mem_funct3 (3) and o_mem_read_write (1; 0=read, 1=write).
REQ-013 The block SHALL have memory-side inputs i_mem_ack (1) and i_mem_data (XLEN).
REQ-014 The block SHALL have result outputs o_wb_valid (1), o_wb_data (XLEN), o_done (1), o_misaligned (1), o_illegal (1), o_bus_error (1) and o_fault_addr (XLEN).

Function
REQ-015 Handshake: an operation SHALL be accepted on a rising edge where i_valid && o_ready && (i_is_load || i_is_store).
REQ-016 o_ready SHALL be 1 only in state IDLE.
REQ-017 An i_valid with neither i_is_load nor i_is_store SHALL be ignored, with no state change and no pulse.
REQ-018 The effective address SHALL be i_base + i_offset modulo 2^XLEN, with carry-out discarded.
REQ-019 An operation SHALL be illegal when both i_is_load and i_is_store are set, when a load has funct3 in {011, 110, 111}, or when a store has funct3 > 010.
REQ-020 Misaligned: halfword (funct3[1:0]=01) with addr[0]=1, or word (funct3[1:0]=10) with addr[1:0]!=00; byte access SHALL never be misaligned.
REQ-021 On accepting an illegal operation, the block SHALL pulse o_illegal for 1 cycle on the next cycle, set o_fault_addr to the address, issue no request, and stay in IDLE.
REQ-022 On accepting a misaligned operation, the block SHALL pulse o_misaligned for 1 cycle on the next cycle, set o_fault_addr to the address, issue no request, and stay in IDLE; illegal SHALL take priority over misaligned.
REQ-023 FSM states SHALL be IDLE, REQ and RELEASE.
REQ-024 IDLE->REQ on a valid accepted operation: o_mem_req=1, with addr, data, funct3 and read_write (1 for store) registered and held stable for the whole of REQ.
REQ-025 In REQ, when i_mem_ack=1 is sampled: load SHALL latch i_mem_data into o_wb_data and pulse o_wb_valid; loads and stores SHALL both pulse o_done; o_mem_req SHALL drop; next state RELEASE.
REQ-026 RELEASE->IDLE when i_mem_ack=0; the block SHALL remain in RELEASE while the ack stays high.
REQ-027 A cycle counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-028 When the counter reaches TIMEOUT, the block SHALL pulse o_bus_error, set o_fault_addr, drop o_mem_req, go to IDLE, and produce no o_wb_valid/o_done.
REQ-029 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-030 Latency with a zero-wait memory: accept at edge N, o_mem_req high from N, o_wb_valid/o_done high N+1 to N+2, o_ready high again from N+2.
REQ-031 o_wb_data SHALL hold its value until the next load completes.
REQ-032 All pulses SHALL be exactly 1 cycle wide.

Reset
REQ-033 While i_rst_n=0, the FSM SHALL be in IDLE with the counter at 0 and every output 0 except o_ready=1.
REQ-034 Reset asserted mid-operation SHALL drop o_mem_req immediately (asynchronously), with no completion or error pulse.

Verification
REQ-035 LW, base 0x100, offset 0x4, zero-wait memory returning 0xDEADBEEF -> o_mem_addr=0x104, o_mem_funct3=010, o_wb_data=0xDEADBEEF with a 1-cycle o_wb_valid.
REQ-036 SB, base 0x203, offset 0, data 0xAB -> o_mem_read_write=1, o_mem_addr=0x203, o_done pulse, o_wb_valid stays 0.
REQ-037 LH at 0x101 and LW at 0x102 -> o_misaligned pulse with o_fault_addr 0x101 and 0x102, and o_mem_req never rises.
REQ-038 LW with funct3=011 -> o_illegal pulse; both i_is_load and i_is_store set -> o_illegal pulse; no request issued.
REQ-039 Memory never acks, TIMEOUT=16 -> o_bus_error exactly 16 cycles after request start, then o_ready=1; an ack on cycle 16 -> success instead.
REQ-040 Reset pulsed while in REQ -> o_mem_req=0 immediately and no pulses; a following LW completes normally.
